// File: rtl/updown_counter_if.sv
// Control/status bundle for updown_counter.
// The tri-state data bus stays a plain port so it can be shared.
interface updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic             up;
  logic [WIDTH-1:0] data_in;
  logic             clr_ovf;
  logic             out_en;
  logic             tc;
  logic             ovf;

  modport master (
    output en, load, up, data_in,
    output clr_ovf, out_en,
    input  tc, ovf
  );

  modport slave (
    input  en, load, up, data_in,
    input  clr_ovf, out_en,
    output tc, ovf
  );
endinterface

// File: rtl/updown_counter.sv
// Parametrised up/down counter with wrap/saturate,
// terminal count, sticky overflow and tri-state output.
module updown_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  updown_counter_if.slave     bus,
  output wire  [WIDTH-1:0]    data_out
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero;
  logic             tc;
  logic [WIDTH-1:0] load_val;

  assign at_max  = (count_q == MAX_VAL);
  assign at_zero = (count_q == '0);

  assign tc = bus.en & ~bus.load &
              ((bus.up & at_max) |
               (~bus.up & at_zero));

  assign load_val = (bus.data_in > MAX_VAL)
                  ? MAX_VAL : bus.data_in;

  // Step only when away from the boundary, so
  // no reliance on WIDTH-bit rollover.
  always_comb begin
    count_d = count_q;
    if (bus.load) begin
      count_d = load_val;
    end else if (bus.en && bus.up) begin
      if (at_max)
        count_d = SATURATE ? count_q : '0;
      else
        count_d = count_q + 1'b1;
    end else if (bus.en) begin
      if (at_zero)
        count_d = SATURATE ? count_q : MAX_VAL;
      else
        count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    ovf_d = tc | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.tc   = tc;
  assign bus.ovf  = ovf_q;
  assign data_out = bus.out_en ? count_q : {WIDTH{1'bz}};

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter, successor to the fixed 8-bit counter. It adds configurable width and modulus, a direction input, and a wrap or saturate mode. It also provides a terminal-count output and a sticky overflow flag. Its tri-state data output is meant to share a bus with other user-project peripherals.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, highest count value; the counter range is 0..MAX_VAL. Must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0, end-of-range behaviour: 0 = wrap at the range ends, 1 = hold at the range ends.

Ports:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, synchronous active-low reset, sampled on the rising edge of clk.
- en, in, 1, count enable.
- load, in, 1, parallel load strobe.
- up, in, 1, count direction: 1 = increment, 0 = decrement.
- data_in, in, WIDTH, parallel load value.
- clr_ovf, in, 1, clears the sticky overflow flag.
- out_en, in, 1, output enable for data_out.
- data_out, out, WIDTH, count value when out_en=1; all bits high-Z when out_en=0.
- tc, out, 1, terminal count; combinational.
- ovf, out, 1, sticky overflow/underflow flag; registered.

## Operation
- State:
  - count[WIDTH-1:0]
  - ovf flag
  - No FSM beyond these registers.
- Update priority per rising edge (highest first):
  1. rst_n=0: count <= 0, ovf <= 0.
  2. load=1: count <= min(data_in, MAX_VAL). en and up are ignored this cycle.
  3. en=1, up=1:
     - If count==MAX_VAL: count <= 0 if SATURATE=0, else count holds.
     - Otherwise count <= count+1.
  4. en=1, up=0:
     - If count==0: count <= MAX_VAL if SATURATE=0, else count holds.
     - Otherwise count <= count-1.
  5. Otherwise count holds.
- Arithmetic:
  - Use unsigned compares against MAX_VAL.
  - Never let the counter exceed MAX_VAL, even when MAX_VAL < 2**WIDTH-1.
  - The increment must not rely on natural WIDTH-bit rollover.
- tc = en & ~load & ((up & count==MAX_VAL) | (~up & count==0)).
  - tc is asserted in the cycle before the boundary step, in both modes.
- ovf:
  - Set on any edge where tc=1, in both wrap and saturate modes. In saturate mode, set only when a step is attempted at the boundary, which is exactly the tc condition.
  - Cleared by clr_ovf=1 when rst_n=1.
  - If set and clear coincide on the same edge, set wins.
  - ovf is unaffected by load.
- data_out:
  - data_out = out_en ? count : {WIDTH{1'bz}}.
  - out_en affects only the output driver, never the count, tc or ovf.
- Reset mid-count: reset takes effect on the next edge regardless of load or en. The outputs are 0 in the following cycle.

## Timing
- Reset values: count=0, ovf=0, tc=en&~load&~up (combinational from inputs), data_out=0 if out_en=1 else Z.
- Load latency: the value appears on data_out one cycle after the edge that samples load=1.
- Count latency: one step per enabled edge. There is no pipeline; data_out is driven directly from the register through the tri-state driver.
- tc and data_out enable are combinational: they follow en, up, load and out_en in the same cycle.
- ovf is visible in the cycle after the boundary edge.
- Inputs are synchronous to clk. No clock-domain crossing inside the block.

## Test plan
Use WIDTH=8, MAX_VAL=9, SATURATE=0 unless stated.
- Reset: hold rst_n=0 for 2 cycles with en=1 and load=1 -> count=0 and ovf=0. With out_en=0, data_out is 8'hZZ; raising out_en gives 0.
- Up wrap: load 7, then en=1, up=1 for 4 cycles -> data_out sequence 7,8,9,0,1. tc is high only while count=9. ovf rises the cycle data_out=0. Pulse clr_ovf -> ovf=0.
- Down wrap and clamp: load 200 -> count=9 (clamped). Then en=1, up=0 from 1 -> data_out 1,0,9. tc is high while count=0.
- Saturate (SATURATE=1, WIDTH=4, MAX_VAL=15):
  - Count up past 15 -> count holds at 15, tc stays high, ovf=1.
  - Reverse to down -> 14,13.
  - clr_ovf together with another boundary step -> ovf stays 1.
- Priority: load=1 with en=1, up=1 and data_in=3 -> count=3, not 4, and tc=0. Toggling out_en mid-count -> count continues unaffected.
- Reset mid-operation: assert rst_n=0 for one cycle at count=5 while counting -> next cycle count=0, then counting resumes 1,2 after rst_n=1.
